// File: rtl/btn_event_router_pkg.sv
// Shared definitions for the button front-end.
//   BTN_*      : bit positions of the four push buttons in the btn vector
//   SW_*       : stopwatch FSM state encodings
//   btn_vec_t  : one bit per button
//   one_hot3   : true when exactly one of three bits is set (auto-repeat qualifier)
package btn_event_router_pkg;

    localparam int NUM_BTN = 4;
    localparam int BTN_U   = 0;
    localparam int BTN_L   = 1;
    localparam int BTN_R   = 2;
    localparam int BTN_D   = 3;

    localparam logic [1:0] SW_STOP  = 2'd0;
    localparam logic [1:0] SW_RUN   = 2'd1;
    localparam logic [1:0] SW_CLEAR = 2'd2;

    typedef logic [NUM_BTN-1:0] btn_vec_t;

    function automatic logic one_hot3(input logic [2:0] v);
        return (v == 3'b001) || (v == 3'b010) || (v == 3'b100);
    endfunction

endpackage

// File: rtl/btn_event_router_if.sv
// Pin-side bundle of the button front-end.
//   btn, sw_mode               : raw board inputs (asynchronous)
//   run, clear, sec, min, hour : control outputs to the stopwatch/watch cores
// master = board/core side, slave = btn_event_router.
interface btn_event_router_if;
    import btn_event_router_pkg::*;

    btn_vec_t btn;
    logic     sw_mode;
    logic     run;
    logic     clear;
    logic     sec;
    logic     min;
    logic     hour;

    modport master (output btn, output sw_mode,
                    input run, input clear, input sec, input min, input hour);
    modport slave  (input btn, input sw_mode,
                    output run, output clear, output sec, output min, output hour);
endinterface

// File: rtl/btn_event_router_debounce.sv
// One button: 2-flop synchroniser, sample-tick shift register, debounced level
// and edge pulses.
//   clk, reset : system clock, synchronous active-high reset
//   tick       : shared sample enable
//   raw        : asynchronous bouncy button
//   level      : debounced level
//   press      : 1-cycle pulse on a debounced rising edge
//   toggle     : 1-cycle pulse on any debounced edge
module btn_event_router_debounce #(
    parameter int DB_DEPTH = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic raw,
    output logic level,
    output logic press,
    output logic toggle
);

    logic [1:0]          sync;
    logic [DB_DEPTH-1:0] shreg;
    logic [DB_DEPTH-1:0] shreg_nxt;
    logic                level_q;

    // Level is decided from the post-shift value so it moves on the deciding tick itself.
    assign shreg_nxt = tick ? {shreg[DB_DEPTH-2:0], sync[1]} : shreg;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync    <= '0;
            shreg   <= '0;
            level   <= 1'b0;
            level_q <= 1'b0;
        end else begin
            sync    <= {sync[0], raw};
            shreg   <= shreg_nxt;
            if (&shreg_nxt) begin
                level <= 1'b1;
            end else if (~|shreg_nxt) begin
                level <= 1'b0;
            end
            level_q <= level;
        end
    end

    assign press  = level & ~level_q;
    assign toggle = level ^ level_q;

endmodule

// File: rtl/btn_event_router.sv
// Button front-end for the stopwatch/watch top level: debounces four buttons and
// routes clean presses by display mode.
//   clk, reset : system clock, synchronous active-high reset
//   bus        : btn/sw_mode in; run/clear/sec/min/hour out (slave modport)
//
// Stopwatch FSM (advances only in stopwatch mode, except CLEAR which always exits)
//   state    | meaning
//   SW_STOP  | stopwatch halted, run=0
//   SW_RUN   | stopwatch counting, run=1
//   SW_CLEAR | one-cycle clear pulse, returns to SW_STOP
module btn_event_router
    import btn_event_router_pkg::*;
#(
    parameter int CLK_HZ        = 100_000_000,
    parameter int SAMPLE_HZ     = 1_000,
    parameter int DB_DEPTH      = 8,
    parameter int REPEAT_DELAY  = 500,
    parameter int REPEAT_PERIOD = 100
) (
    input  logic              clk,
    input  logic              reset,
    btn_event_router_if.slave bus
);

    localparam int TICK_DIV = CLK_HZ / SAMPLE_HZ;
    localparam int TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int REP_W    = $clog2(REPEAT_DELAY + 1);

    localparam logic [TICK_W-1:0] TICK_RELOAD = TICK_W'(TICK_DIV - 1);
    localparam logic [REP_W-1:0]  REP_FIRE_AT = REP_W'(REPEAT_DELAY);
    localparam logic [REP_W-1:0]  REP_RELOAD  = REP_W'(REPEAT_DELAY - REPEAT_PERIOD);

    logic [TICK_W-1:0] tick_cnt;
    logic              tick;
    logic [1:0]        mode_sync;
    logic              mode;
    btn_vec_t          db;
    btn_vec_t          press;
    btn_vec_t          toggle;
    logic              unused_u;
    logic [1:0]        sw_state;
    logic [1:0]        sw_nxt;
    logic [REP_W-1:0]  rep_cnt;
    logic [REP_W-1:0]  rep_nxt;
    logic              rep_clr;
    logic              rep_fire;
    logic              sec_r;
    logic              min_r;
    logic              hour_r;

    // Sample tick: down-counter, tick on terminal count.
    assign tick = (tick_cnt == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            tick_cnt  <= '0;
            mode_sync <= '0;
        end else begin
            tick_cnt  <= tick ? TICK_RELOAD : tick_cnt - 1'b1;
            mode_sync <= {mode_sync[0], bus.sw_mode};
        end
    end

    assign mode = mode_sync[1];

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_db
        btn_event_router_debounce #(.DB_DEPTH(DB_DEPTH)) u_db (
            .clk    (clk),
            .reset  (reset),
            .tick   (tick),
            .raw    (bus.btn[i]),
            .level  (db[i]),
            .press  (press[i]),
            .toggle (toggle[i])
        );
    end

    // U only matters through its press pulse.
    assign unused_u = db[BTN_U] ^ toggle[BTN_U];

    always_comb begin
        sw_nxt = sw_state;
        case (sw_state)
            SW_STOP: begin
                if (!mode && press[BTN_U]) begin
                    sw_nxt = SW_RUN;
                end else if (!mode && press[BTN_D]) begin
                    sw_nxt = SW_CLEAR;
                end
            end
            SW_RUN: begin
                if (!mode && press[BTN_U]) begin
                    sw_nxt = SW_STOP;
                end
            end
            default: sw_nxt = SW_STOP;
        endcase
    end

    // Repeat counter holds ticks since the held button's press; it is reloaded
    // back one period after each repeat so it never exceeds REPEAT_DELAY.
    assign rep_clr  = !mode || !one_hot3(db[BTN_D:BTN_L]) || (|toggle[BTN_D:BTN_L]);
    assign rep_nxt  = rep_cnt + 1'b1;
    assign rep_fire = tick && !rep_clr && (rep_nxt == REP_FIRE_AT);

    always_ff @(posedge clk) begin
        if (reset) begin
            sw_state <= SW_STOP;
            rep_cnt  <= '0;
            sec_r    <= 1'b0;
            min_r    <= 1'b0;
            hour_r   <= 1'b0;
        end else begin
            sw_state <= sw_nxt;
            if (rep_clr) begin
                rep_cnt <= '0;
            end else if (tick) begin
                rep_cnt <= rep_fire ? REP_RELOAD : rep_nxt;
            end
            sec_r  <= mode && (press[BTN_D] || (rep_fire && db[BTN_D]));
            min_r  <= mode && (press[BTN_R] || (rep_fire && db[BTN_R]));
            hour_r <= mode && (press[BTN_L] || (rep_fire && db[BTN_L]));
        end
    end

    assign bus.run   = (sw_state == SW_RUN);
    assign bus.clear = (sw_state == SW_CLEAR);
    assign bus.sec   = sec_r;
    assign bus.min   = min_r;
    assign bus.hour  = hour_r;

endmodule

// File: tb/tb_btn_event_router.sv
module tb_btn_event_router;

    localparam int T  = 10;   // clocks per sample tick
    localparam int D  = 4;    // debounce depth
    localparam int RD = 50;   // repeat delay, ticks
    localparam int RP = 10;   // repeat period, ticks

    localparam int K_RISE  = 0;
    localparam int K_FALL  = 1;
    localparam int K_CLEAR = 2;
    localparam int K_SEC   = 3;
    localparam int K_MIN   = 4;
    localparam int K_HOUR  = 5;

    typedef struct {
        int kind;
        int lo;
        int hi;
        bit rel;   // window relative to the previous observed event
    } exp_t;

    logic  clk   = 1'b0;
    logic  reset = 1'b1;
    int    cyc   = 0;
    int    checks   = 0;
    int    failures = 0;
    bit    mon_en   = 1'b0;
    logic  run_prev = 1'b0;
    int    last_evt = 0;
    exp_t  exp_q[$];
    string kname[6] = '{"run_rise", "run_fall", "clear", "sec", "min", "hour"};

    // reference model state
    bit running = 1'b0;
    bit mode_m  = 1'b0;

    btn_event_router_if bus ();

    btn_event_router #(
        .CLK_HZ        (1000),
        .SAMPLE_HZ     (100),
        .DB_DEPTH      (D),
        .REPEAT_DELAY  (RD),
        .REPEAT_PERIOD (RP)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time exceeded, required completion");
        $fatal(1, "watchdog");
    end

    function automatic void push(input int k, input int lo, input int hi, input bit rel);
        exp_t e;
        e.kind = k;
        e.lo   = lo;
        e.hi   = hi;
        e.rel  = rel;
        exp_q.push_back(e);
    endfunction

    function automatic void see(input int k);
        exp_t e;
        int   lo;
        int   hi;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_%s: got event at cycle %0d, required no event", kname[k], cyc);
        end else begin
            e  = exp_q.pop_front();
            lo = e.rel ? last_evt + e.lo : e.lo;
            hi = e.rel ? last_evt + e.hi : e.hi;
            if (e.kind != k || cyc < lo || cyc > hi)  begin
                failures++;
                $display("FAIL event_%s: got %s at cycle %0d, required %s in cycles [%0d,%0d]",
                         kname[e.kind], kname[k], cyc, kname[e.kind], lo, hi);
            end
        end
        last_evt = cyc;
    endfunction

    // Monitor: every output event pops the scoreboard in a fixed order.
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.run && !run_prev) see(K_RISE);
            if (!bus.run && run_prev) see(K_FALL);
            if (bus.clear) see(K_CLEAR);
            if (bus.sec)   see(K_SEC);
            if (bus.min)   see(K_MIN);
            if (bus.hour)  see(K_HOUR);
        end
        run_prev <= bus.run;
    end

    function automatic void chk(input string name, input logic got, input logic req);
        checks++;
        if (got !== req) begin
            failures++;
            $display("FAIL %s: got %b, required %b", name, got, req);
        end
    endfunction

    // Behavioural model of one press. A clean edge at b (last bounce at s) is
    // debounced after 2 sync clocks + (D-1) ticks, +1 for the press pulse, with
    // up to one tick of jitter, then registered onto the outputs.
    function automatic void model_press(input logic [3:0] m, input int b, input int s, input int nrep);
        int lo;
        int hi;
        bit first;
        int held_kind;
        lo        = b + 2 + (D - 1) * T + 1;
        hi        = s + 2 + D * T + 2;
        first     = 1'b1;
        held_kind = K_SEC;
        if (!mode_m) begin
            if (m[0]) begin
                push(running ? K_FALL : K_RISE, lo, hi, 1'b0);
                running = !running;
            end else if (m[3] && !running) begin
                push(K_CLEAR, lo, hi, 1'b0);
            end
        end else begin
            if (m[3]) begin push(K_SEC, lo, hi, 1'b0); first = 1'b0; held_kind = K_SEC; end
            if (m[2]) begin
                if (first) push(K_MIN, lo, hi, 1'b0); else push(K_MIN, 0, 0, 1'b1);
                first = 1'b0; held_kind = K_MIN;
            end
            if (m[1]) begin
                if (first) push(K_HOUR, lo, hi, 1'b0); else push(K_HOUR, 0, 0, 1'b1);
                held_kind = K_HOUR;
            end
            if ($countones(m[3:1]) == 1) begin
                for (int j = 0; j < nrep; j++) begin
                    if (j == 0) push(held_kind, RD * T - 2, RD * T + 2, 1'b1);
                    else        push(held_kind, RP * T - 1, RP * T + 1, 1'b1);
                end
            end
        end
    endfunction

    task automatic set_mode(input bit m);
        @(negedge clk);
        bus.sw_mode = m;
        mode_m      = m;
        repeat (6) @(negedge clk);
    endtask

    task automatic press(input logic [3:0] mask, input bit bounce, output int b, output int s);
        int n;
        int gap;
        @(negedge clk);
        b = cyc;
        if (bounce) begin
            n = $urandom_range(2, 6);
            for (int k = 0; k < n; k++) begin
                bus.btn = bus.btn ^ mask;
                gap     = $urandom_range(1, 4);
                repeat (gap) @(negedge clk);
            end
        end
        bus.btn = bus.btn | mask;
        s = cyc;
    endtask

    task automatic hold_release(input logic [3:0] mask, input int hold_clk);
        repeat (hold_clk) @(negedge clk);
        bus.btn = bus.btn & ~mask;
        repeat (2 + D * T + 10) @(negedge clk);
    endtask

    task automatic drain(input int limit);
        exp_t e;
        for (int k = 0; k < limit && exp_q.size() > 0; k++) @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            failures++;
            $display("FAIL missing_%s: got no event by cycle %0d, required one", kname[e.kind], cyc);
        end
    endtask

    task automatic do_press(input logic [3:0] mask, input bit bounce, input int hold_clk, input int nrep);
        int b;
        int s;
        press(mask, bounce, b, s);
        model_press(mask, b, s, nrep);
        hold_release(mask, hold_clk);
        drain(200);
    endtask

    initial begin
        int b;
        int s;
        int c;
        logic [3:0] mask;
        int nrep;
        int hold;

        bus.btn     = '0;
        bus.sw_mode = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_run",   bus.run,   1'b0);
        chk("reset_clear", bus.clear, 1'b0);
        chk("reset_sec",   bus.sec,   1'b0);
        chk("reset_min",   bus.min,   1'b0);
        chk("reset_hour",  bus.hour,  1'b0);
        reset  = 1'b0;
        mon_en = 1'b1;
        repeat (5) @(negedge clk);

        // start / stop with clean U presses
        do_press(4'b0001, 1'b0, 20 * T, 0);
        do_press(4'b0001, 1'b0, 20 * T, 0);

        // bouncy D in STOP: one clear pulse, run unchanged
        @(negedge clk);
        b = cyc;
        for (int k = 0; k < 10; k++) begin
            bus.btn[3] = ~bus.btn[3];
            repeat (3) @(negedge clk);
        end
        bus.btn[3] = 1'b1;
        s = cyc;
        model_press(4'b1000, b, s, 0);
        hold_release(4'b1000, 20 * T);
        drain(200);

        // RUN ignores D; watch mode freezes the stopwatch
        do_press(4'b0001, 1'b0, 15 * T, 0);
        do_press(4'b1000, 1'b1, 15 * T, 0);
        set_mode(1'b1);
        do_press(4'b0001, 1'b0, 15 * T, 0);
        set_mode(1'b0);
        do_press(4'b0001, 1'b0, 15 * T, 0);

        // watch mode: held R auto-repeats; L+R together does not
        set_mode(1'b1);
        do_press(4'b0100, 1'b0, (45 + 10 * 5) * T, 5);
        do_press(4'b0110, 1'b0, 95 * T, 0);

        // leaving watch mode while held: press only, no repeats
        press(4'b1000, 1'b0, b, s);
        model_press(4'b1000, b, s, 0);
        repeat (20 * T) @(negedge clk);
        set_mode(1'b0);
        hold_release(4'b1000, 75 * T);
        drain(200);

        // randomized presses against the model
        for (int it = 0; it < 10; it++) begin
            set_mode(1'($urandom_range(0, 1)));
            mask = 4'($urandom_range(1, 15));
            nrep = 0;
            if (mode_m && $countones(mask[3:1]) == 1) begin
                nrep = $urandom_range(0, 4);
                hold = (nrep == 0) ? $urandom_range(20, 40) * T : (45 + 10 * nrep) * T;
            end else begin
                hold = $urandom_range(15, 40) * T;
            end
            do_press(mask, 1'($urandom_range(0, 1)), hold, nrep);
        end

        // U and D together in STOP: run wins; then reset while running with U held
        set_mode(1'b0);
        if (running) do_press(4'b0001, 1'b0, 15 * T, 0);
        press(4'b1001, 1'b0, b, s);
        model_press(4'b1001, b, s, 0);
        repeat (15 * T) @(negedge clk);
        bus.btn[3] = 1'b0;
        repeat (2 + D * T + 10) @(negedge clk);
        drain(200);
        @(negedge clk);
        c = cyc;
        push(K_FALL, c + 1, c + 1, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        b = cyc;
        running = 1'b0;
        model_press(4'b0001, b, b, 0);
        drain(200);
        hold_release(4'b0001, 10 * T);
        drain(50);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
